// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encoding and default width.
package serial_adder_pkg;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell: the only arithmetic in the serial adder datapath.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);
  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock through a single full_adder.
// Optional SERIAL_ADDER_SUB_EN adds a 'sub' port for a-b via inverted b and forced carry-in.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_shift, b_ld;
  logic             carry, cin_ld, fa_s, fa_c, last, load;
  logic [CW-1:0]    cnt;

  assign last = (cnt == CW'(WIDTH - 1));
  assign load = start && ready;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_ld   = sub ? ~b : b;
  assign cin_ld = sub ? 1'b1 : cin;
`else
  assign b_ld   = b;
  assign cin_ld = cin;
`endif

  full_adder u_fa (
    .x (a_sr[0]),
    .y (b_sr[0]),
    .z (carry),
    .s (fa_s),
    .c (fa_c)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 lands at sum[0].
  always_comb begin
    sum_shift            = sum_sr >> 1;
    sum_shift[WIDTH-1]   = fa_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // sum/cout live in their own registers so a back-to-back load of sum_sr
  // does not disturb the previous result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (load) begin
      a_sr   <= a;
      b_sr   <= b_ld;
      carry  <= cin_ld;
      cnt    <= '0;
      sum_sr <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= sum_shift;
      carry  <= fa_c;
      cnt    <= cnt + CW'(1);
      if (last) begin
        sum  <= sum_shift;
        cout <= fa_c;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances; sub tests when SERIAL_ADDER_SUB_EN is set.
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ready8, busy8, done8, cout8;
  logic [7:0] sum8;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub8 = 1'b0;
`endif

  logic       start1 = 1'b0, cin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       ready1, busy1, done1, cout1;
  logic [0:0] sum1;

  typedef struct {logic [7:0] s; logic c;} exp8_t;
  exp8_t      q8[$];
  logic [1:0] q1[$];

  int tests = 0;
  int fails = 0;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic test_reset;
    #1;
    tests++;
    if (sum8 !== 8'h00 || cout8 !== 1'b0 || done8 !== 1'b0 || busy8 !== 1'b0 || ready8 !== 1'b1)
      begin fails++; $display("FAIL reset8: sum=%h cout=%b done=%b busy=%b ready=%b exp 00/0/0/0/1", sum8, cout8, done8, busy8, ready8); end
    tests++;
    if (sum1 !== 1'b0 || cout1 !== 1'b0 || done1 !== 1'b0 || busy1 !== 1'b0 || ready1 !== 1'b1)
      begin fails++; $display("FAIL reset1: sum=%h cout=%b done=%b busy=%b ready=%b exp 0/0/0/0/1", sum1, cout1, done1, busy1, ready1); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    logic [7:0] ta_tab[5] = '{8'h5A, 8'hFF, 8'hFF, 8'h00, 8'h80};
    logic [7:0] tb_tab[5] = '{8'h33, 8'h01, 8'hFF, 8'h00, 8'h80};
    logic       tc_tab[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      logic [7:0] ta, tb;
      logic       tc;
      logic [8:0] t;
      exp8_t      e;
      int         lat, bz;
      if (i < 5) begin ta = ta_tab[i]; tb = tb_tab[i]; tc = tc_tab[i]; end
      else begin ta = 8'($urandom); tb = 8'($urandom); tc = 1'($urandom); end
      @(negedge clk);
      a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
      t = {1'b0, ta} + {1'b0, tb} + {8'h00, tc};
      q8.push_back('{t[7:0], t[8]});
      @(posedge clk); #1 start8 = 1'b0;
      lat = -1; bz = 0;
      for (int k = 0; k < 20; k++) begin
        if (k > 0) begin @(posedge clk); #1; end
        if (busy8) bz++;
        if (done8) begin lat = k; break; end
      end
      tests++;
      if (lat != 8) begin fails++; $display("FAIL add_latency[%0d]: got %0d exp 8", i, lat); end
      tests++;
      if (bz != 8) begin fails++; $display("FAIL add_busy[%0d]: got %0d exp 8", i, bz); end
      e = q8.size() > 0 ? q8.pop_front() : '{8'hxx, 1'bx};
      tests++;
      if (sum8 !== e.s || cout8 !== e.c)
        begin fails++; $display("FAIL add_result[%0d] %h+%h+%b: got %h/%b exp %h/%b", i, ta, tb, tc, sum8, cout8, e.s, e.c); end
      @(posedge clk); #1;
      tests++;
      if (done8 !== 1'b0 || ready8 !== 1'b1 || sum8 !== e.s || cout8 !== e.c)
        begin fails++; $display("FAIL add_hold[%0d]: done=%b ready=%b sum=%h cout=%b exp 0/1/%h/%b", i, done8, ready8, sum8, cout8, e.s, e.c); end
    end
  endtask

  task automatic test_back_to_back;
    int    lat;
    exp8_t e;
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back('{8'h46, 1'b0});
    @(posedge clk); #1 start8 = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (done8) begin lat = k; break; end
      if (k == 3) begin a8 = 8'h00; b8 = 8'h00; start8 = 1'b1; end
      if (k == 4) start8 = 1'b0;
    end
    tests++;
    if (lat != 8) begin fails++; $display("FAIL ignore_latency: got %0d exp 8", lat); end
    e = q8.size() > 0 ? q8.pop_front() : '{8'hxx, 1'bx};
    tests++;
    if (sum8 !== e.s || cout8 !== e.c)
      begin fails++; $display("FAIL ignore_result: got %h/%b exp %h/%b", sum8, cout8, e.s, e.c); end
    // still in DONE: start here must go straight back to RUN
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1; start8 = 1'b1;
    q8.push_back('{8'h01, 1'b1});
    @(posedge clk); #1 start8 = 1'b0;
    tests++;
    if (busy8 !== 1'b1 || ready8 !== 1'b0)
      begin fails++; $display("FAIL b2b_no_idle: busy=%b ready=%b exp 1/0", busy8, ready8); end
    tests++;
    if (sum8 !== 8'h46 || cout8 !== 1'b0)
      begin fails++; $display("FAIL b2b_hold: got %h/%b exp 46/0", sum8, cout8); end
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (done8) begin lat = k; break; end
    end
    tests++;
    if (lat != 8) begin fails++; $display("FAIL b2b_latency: got %0d exp 8", lat); end
    e = q8.size() > 0 ? q8.pop_front() : '{8'hxx, 1'bx};
    tests++;
    if (sum8 !== e.s || cout8 !== e.c)
      begin fails++; $display("FAIL b2b_result: got %h/%b exp %h/%b", sum8, cout8, e.s, e.c); end
  endtask

  task automatic test_abort;
    int    lat;
    bit    seen;
    exp8_t e;
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy8 !== 1'b1) begin fails++; $display("FAIL abort_pre_busy: got %b exp 1", busy8); end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (sum8 !== 8'h00 || cout8 !== 1'b0 || done8 !== 1'b0 || busy8 !== 1'b0 || ready8 !== 1'b1)
      begin fails++; $display("FAIL abort_outputs: sum=%h cout=%b done=%b busy=%b ready=%b exp 00/0/0/0/1", sum8, cout8, done8, busy8, ready8); end
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (done8) seen = 1'b1; end
    tests++;
    if (seen) begin fails++; $display("FAIL abort_no_done: got done=1 exp 0"); end
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b1; start8 = 1'b1;
    q8.push_back('{8'h11, 1'b0});
    @(posedge clk); #1 start8 = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (done8) begin lat = k; break; end
    end
    e = q8.size() > 0 ? q8.pop_front() : '{8'hxx, 1'bx};
    tests++;
    if (lat != 8 || sum8 !== e.s || cout8 !== e.c)
      begin fails++; $display("FAIL abort_recover: lat=%0d got %h/%b exp lat 8 %h/%b", lat, sum8, cout8, e.s, e.c); end
  endtask

  task automatic test_width1;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] n, e;
      int         lat;
      v = 3'(i);
      @(negedge clk);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      n = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
      q1.push_back(n);
      @(posedge clk); #1 start1 = 1'b0;
      lat = -1;
      for (int k = 0; k < 10; k++) begin
        if (k > 0) begin @(posedge clk); #1; end
        if (done1) begin lat = k; break; end
      end
      e = q1.size() > 0 ? q1.pop_front() : 2'bxx;
      tests++;
      if (lat != 1 || sum1[0] !== e[0] || cout1 !== e[1])
        begin fails++; $display("FAIL w1[%0d]: lat=%0d got s=%b c=%b exp lat 1 s=%b c=%b", i, lat, sum1[0], cout1, e[0], e[1]); end
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    logic [7:0] sa[3] = '{8'h10, 8'h01, 8'h21};
    logic [7:0] sb[3] = '{8'h01, 8'h02, 8'h13};
    logic       ss[3] = '{1'b1, 1'b1, 1'b0};
    exp8_t      ex[3] = '{'{8'h0F, 1'b1}, '{8'hFF, 1'b0}, '{8'h34, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      int    lat;
      exp8_t e;
      @(negedge clk);
      a8 = sa[i]; b8 = sb[i]; cin8 = 1'b0; sub8 = ss[i]; start8 = 1'b1;
      q8.push_back(ex[i]);
      @(posedge clk); #1 start8 = 1'b0;
      lat = -1;
      for (int k = 0; k < 20; k++) begin
        if (k > 0) begin @(posedge clk); #1; end
        if (done8) begin lat = k; break; end
      end
      e = q8.size() > 0 ? q8.pop_front() : '{8'hxx, 1'bx};
      tests++;
      if (lat != 8 || sum8 !== e.s || cout8 !== e.c)
        begin fails++; $display("FAIL sub[%0d]: lat=%0d got %h/%b exp lat 8 %h/%b", i, lat, sum8, cout8, e.s, e.c); end
    end
    sub8 = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_add;
    test_back_to_back;
    test_abort;
    test_width1;
`ifdef SERIAL_ADDER_SUB_EN
    test_sub;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
